// File: rtl/mul_sched_pkg.sv
// Shared types and helpers for the shared-multiplier scheduler and its arbiter.
package mul_sched_pkg;

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  // Ceiling log2, never narrower than one bit so one-entry fields stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int N_REQ_DEFAULT = 4;
  localparam int ID_W          = clog2(N_REQ_DEFAULT);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... modulo N and
// returns a one-hot grant plus its encoded index.
module rr_arbiter
  import mul_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Indices above the pointer are searched first, then the wrap-around part.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!o_any && i_req[j] && (j > int'(i_ptr))) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!o_any && i_req[j] && (j <= int'(i_ptr))) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mul_share_sched.sv
// Time-shares one external combinational multiplier between N_REQ requesters,
// treating the multiplier as a SETTLE_CYC multicycle path.
module mul_share_sched
  import mul_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_k,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [clog2(N_REQ)-1:0]  rsp_id,
  output logic [2*WIDTH-1:0]       rsp_k,
  output logic                     busy
);

  localparam int IDW   = clog2(N_REQ);
  localparam int CNT_W = clog2(SETTLE_CYC + 1);

  generate
    if (SETTLE_CYC < 1) begin : g_bad_settle
      $error("SETTLE_CYC must be at least 1");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("N_REQ must be in 2..8");
    end
  endgenerate

  state_t             r_state;
  state_t             w_next;
  logic [IDW-1:0]     r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic [2*WIDTH-1:0] r_rsp_k;
  logic [IDW-1:0]     r_rsp_id;
  logic               r_rsp_valid;
  logic [N_REQ-1:0]   w_grant;
  logic [IDW-1:0]     w_gidx;
  logic               w_any;
  logic               w_accept;

  rr_arbiter #(.N(N_REQ), .IW(IDW)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  assign w_accept  = (r_state == IDLE) && w_any;
  assign req_ready = (r_state == IDLE) ? w_grant : '0;
  assign busy      = (r_state != IDLE);
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_k     = r_rsp_k;
  assign rsp_id    = r_rsp_id;
  assign rsp_valid = r_rsp_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = MUL;
      MUL:     if (r_cnt == '0) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Operands are only loaded on accept, so the multiplier inputs stay quiet
  // while settling and while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= IDW'(N_REQ - 1);
      r_cnt       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_rsp_k     <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mul_a  <= req_a[w_gidx*WIDTH +: WIDTH];
            r_mul_b  <= req_b[w_gidx*WIDTH +: WIDTH];
            r_rsp_id <= w_gidx;
            r_ptr    <= w_gidx;
            r_cnt    <= CNT_W'(SETTLE_CYC - 1);
          end
        end
        MUL: begin
          if (r_cnt == '0) begin
            r_rsp_k     <= mul_k;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
